seq_serializer: RTL and testbench

Serial pattern transmitter, the sending counterpart to the lab's bit-serial sequence detector. A rising edge on `start` latches a parallel word, and the block shifts it out MSB-first, one bit per `DIV` clocks, with valid, first-bit and per-bit strobes. It sits between the board switch/button inputs and any bit-serial consumer, such as a pattern detector or an LED/scope probe.

---
 rtl/seq_pkg.sv | 13 +
 rtl/edge_rise.sv | 21 ++
 rtl/seq_serializer.sv | 124 ++++++++++++
 tb/tb_seq_serializer.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared types and default parameters for the serial pattern transmitter.
package seq_pkg;

  localparam int unsigned WIDTH_DEF = 8;
  localparam int unsigned DIV_DEF   = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } seq_state_e;

endpackage

// File: rtl/edge_rise.sv
// Rising-edge detector for a level input synchronous to clk.
module edge_rise #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rstn,
  input  logic din,
  output logic rise_c
);

  logic din_q;

  // A reset value of 1 forces the input to be seen low before a rise can count.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) din_q <= RST_VAL;
    else       din_q <= din;
  end

  assign rise_c = din & ~din_q;

endmodule

// File: rtl/seq_serializer.sv
// MSB-first serial transmitter: latches a word on a start rise and shifts
// it out one bit per DIV clocks with valid, first-bit and per-bit strobes.
module seq_serializer
  import seq_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned DIV   = DIV_DEF
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic [WIDTH-1:0] data,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             bit_stb,
  output logic             sof,
  output logic             busy,
  output logic             done
);

  localparam int unsigned DCW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned BCW = $clog2(WIDTH);
  localparam logic [DCW-1:0] DIV_LAST = DCW'(DIV - 1);
  localparam logic [BCW-1:0] BIT_LAST = BCW'(WIDTH - 1);

  seq_state_e       state, state_d;
  logic [WIDTH-1:0] shreg, shreg_d;
  logic [BCW-1:0]   bit_cnt, bit_cnt_d;
  logic [DCW-1:0]   div_cnt, div_cnt_d;
  logic             ser_out_d, ser_valid_d, bit_stb_d, sof_d, done_d;
  logic             start_rise;

  edge_rise #(.RST_VAL(1'b1)) u_start_edge (
    .clk    (clk),
    .rstn   (rstn),
    .din    (start),
    .rise_c (start_rise)
  );

  // Next state, datapath and next output values; shreg[WIDTH-1] is the bit on the line.
  always_comb begin
    state_d     = state;
    shreg_d     = shreg;
    bit_cnt_d   = bit_cnt;
    div_cnt_d   = div_cnt;
    ser_out_d   = 1'b0;
    ser_valid_d = 1'b0;
    bit_stb_d   = 1'b0;
    sof_d       = 1'b0;
    done_d      = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start_rise) begin
          state_d     = SEND;
          shreg_d     = data;
          bit_cnt_d   = BIT_LAST;
          div_cnt_d   = '0;
          ser_out_d   = data[WIDTH-1];
          ser_valid_d = 1'b1;
          bit_stb_d   = 1'b1;
          sof_d       = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      SEND: begin
        ser_valid_d = 1'b1;
        ser_out_d   = shreg[WIDTH-1];
        if (div_cnt == DIV_LAST) begin
          div_cnt_d = '0;
          if (bit_cnt == '0) begin
            state_d     = DONE;
            ser_valid_d = 1'b0;
            ser_out_d   = 1'b0;
            done_d      = 1'b1;
          end else begin
            shreg_d   = shreg << 1;
            bit_cnt_d = bit_cnt - BCW'(1);
            ser_out_d = shreg[WIDTH-2];
            bit_stb_d = 1'b1;
          end
        end else begin
          div_cnt_d = div_cnt + DCW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
      div_cnt <= '0;
    end else begin
      state   <= state_d;
      shreg   <= shreg_d;
      bit_cnt <= bit_cnt_d;
      div_cnt <= div_cnt_d;
    end
  end

  // Output registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ser_out   <= 1'b0;
      ser_valid <= 1'b0;
      bit_stb   <= 1'b0;
      sof       <= 1'b0;
      done      <= 1'b0;
    end else begin
      ser_out   <= ser_out_d;
      ser_valid <= ser_valid_d;
      bit_stb   <= bit_stb_d;
      sof       <= sof_d;
      done      <= done_d;
    end
  end

  assign busy = ser_valid;

endmodule

// File: tb/tb_seq_serializer.sv
// Bench for seq_serializer: DIV=1 and DIV=3 instances share one stimulus
// stream and are compared every cycle against a frame-timing model.
module tb_seq_serializer;

  localparam int W = 8;

  logic       clk   = 1'b0;
  logic       rstn  = 1'b0;
  logic       start = 1'b0;
  logic [7:0] data  = 8'h00;

  logic so[2], sv[2], stb[2], sf[2], bz[2], dn[2];

  int n_vec = 0;
  int n_err = 0;

  // Model: a frame accepted at edge f shows on the outputs after edges f..f+W*DIV-1.
  int         div_of[2] = '{1, 3};
  int         cyc = 0;
  bit         act[2];
  int         f[2];
  logic [7:0] w[2];
  logic       prev_start = 1'b1;

  always #5 clk = ~clk;

  seq_serializer #(.WIDTH(W), .DIV(1)) u_div1 (
    .clk(clk), .rstn(rstn), .start(start), .data(data),
    .ser_out(so[0]), .ser_valid(sv[0]), .bit_stb(stb[0]),
    .sof(sf[0]), .busy(bz[0]), .done(dn[0])
  );

  seq_serializer #(.WIDTH(W), .DIV(3)) u_div3 (
    .clk(clk), .rstn(rstn), .start(start), .data(data),
    .ser_out(so[1]), .ser_valid(sv[1]), .bit_stb(stb[1]),
    .sof(sf[1]), .busy(bz[1]), .done(dn[1])
  );

  task automatic chk(input string tag, input int i, input logic got, input logic exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s div%0d cyc %0d: observed %b expected %b", tag, div_of[i], cyc, got, exp);
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 2; i++) begin
      int   r;
      int   wd;
      logic ev, es, eb, eo, ed;
      wd = W * div_of[i];
      r  = cyc - f[i];
      ev = act[i] && (r >= 0) && (r < wd);
      es = ev ? w[i][W - 1 - (r / div_of[i])] : 1'b0;
      eb = ev && ((r % div_of[i]) == 0);
      eo = ev && (r == 0);
      ed = act[i] && (r == wd);
      chk("ser_out",   i, so[i],  es);
      chk("ser_valid", i, sv[i],  ev);
      chk("bit_stb",   i, stb[i], eb);
      chk("sof",       i, sf[i],  eo);
      chk("busy",      i, bz[i],  ev);
      chk("done",      i, dn[i],  ed);
    end
  endtask

  task automatic step(input logic s, input logic [7:0] d);
    start = s;
    data  = d;
    @(posedge clk);
    cyc++;
    if (rstn) begin
      bit rise;
      rise = s && !prev_start;
      for (int i = 0; i < 2; i++) begin
        if (rise && (!act[i] || (cyc - 1 - f[i]) >= W * div_of[i])) begin
          act[i] = 1'b1;
          f[i]   = cyc;
          w[i]   = d;
        end
      end
      prev_start = s;
    end
    #1 check_all();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 8'($urandom));
  endtask

  task automatic async_reset(input logic s, input int n);
    rstn       = 1'b0;
    act[0]     = 1'b0;
    act[1]     = 1'b0;
    prev_start = 1'b1;
    #1 check_all();
    for (int k = 0; k < n; k++) step(s, 8'($urandom));
    rstn = 1'b1;
  endtask

  initial begin
    act[0] = 1'b0; act[1] = 1'b0;
    f[0] = 0; f[1] = 0;
    w[0] = 8'h00; w[1] = 8'h00;

    // Power-on reset for 3 cycles, then 20 quiet cycles.
    async_reset(1'b0, 3);
    idle(20);

    // Single frames: 0x96 then 0xA5, data scrambled after acceptance.
    step(1'b1, 8'h96);
    idle(30);
    step(1'b1, 8'hA5);
    idle(30);

    // start held high for 40 cycles with data changing underneath.
    for (int k = 0; k < 40; k++) step(1'b1, (k < 20) ? 8'hC5 : 8'h00);
    idle(30);

    // Second rise mid-frame with data zeroed.
    step(1'b1, 8'h69);
    step(1'b0, 8'h00);
    step(1'b0, 8'h00);
    step(1'b1, 8'h00);
    step(1'b1, 8'h00);
    idle(30);

    // Rise landing in the DONE cycle of the DIV=1 frame.
    step(1'b1, 8'hE1);
    for (int k = 0; k < 8; k++) step(1'b0, 8'($urandom));
    step(1'b1, 8'h3C);
    idle(30);

    // Random start/data activity.
    for (int k = 0; k < 400; k++) step(1'($urandom_range(0, 2) == 0), 8'($urandom));
    idle(30);

    // Reset during bit 4 with start held high across release.
    step(1'b1, 8'hB7);
    for (int k = 0; k < 3; k++) step(1'b1, 8'($urandom));
    async_reset(1'b1, 2);
    for (int k = 0; k < 6; k++) step(1'b1, 8'($urandom));
    step(1'b0, 8'h00);
    step(1'b1, 8'h5E);
    idle(30);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
